wb_write_queue: RTL and testbench

//   Write-back side producer for the general register file. Collects results from
//   the ALU and memory paths and drives the file's write port with at most one

---
 rtl/wb_write_queue.sv | 136 +++++++++++++
 tb/tb_wb_write_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back queue feeding the register file write port.
// Accepts memory and ALU results, drains one per cycle, forwards queued values.
module wb_write_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       drain_en,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          q1_addr,
    input  logic [ADDR_W-1:0]          q2_addr,
    output logic                       q1_hit,
    output logic                       q2_hit,
    output logic [DATA_W-1:0]          q1_data,
    output logic [DATA_W-1:0]          q2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AM1  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_AM2  = CW'(DEPTH - 2);

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // Status and handshake derive only from the registered occupancy;
    // a pop in the same cycle never frees a slot early.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign mem_ready = (count_q < CNT_FULL);
    assign alu_ready = (count_q <= CNT_AM2) |
                       ((count_q == CNT_AM1) & ~mem_valid);

    assign mem_push = mem_valid & mem_ready;
    assign alu_push = alu_valid & alu_ready;

    // Head entry drives the file; it pops on the edge after being written.
    assign pop             = ~empty & drain_en;
    assign rf_write_enable = pop;
    assign rf_write_addr   = ent_addr_q[head_q];
    assign rf_write_data   = ent_data_q[head_q];

    // Next-state: mem result takes the tail, a same-cycle ALU result the slot after it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr_d[i] = ent_addr_q[i];
            ent_data_d[i] = ent_data_q[i];
        end
        alu_slot = tail_q + PW'(mem_push);
        if (mem_push) begin
            ent_addr_d[tail_q] = mem_addr;
            ent_data_d[tail_q] = mem_data;
        end
        if (alu_push) begin
            ent_addr_d[alu_slot] = alu_addr;
            ent_data_d[alu_slot] = alu_data;
        end
        tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    // Forwarding: walk occupied slots oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        q1_hit  = 1'b0;
        q2_hit  = 1'b0;
        q1_data = '0;
        q2_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (ent_addr_q[idx] == q1_addr) begin
                    q1_hit  = 1'b1;
                    q1_data = ent_data_q[idx];
                end
                if (ent_addr_q[idx] == q2_addr) begin
                    q2_hit  = 1'b1;
                    q2_data = ent_data_q[idx];
                end
            end
        end
    end

    // State registers; reset drops every pending entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= ent_addr_d[i];
                ent_data_q[i] <= ent_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: scoreboard bench for wb_write_queue.
// Accepted results are queued; a negedge monitor checks each file write.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid, drain_en;
    logic        mem_ready, alu_ready;
    logic [2:0]  mem_addr, alu_addr, q1_addr, q2_addr;
    logic [15:0] mem_data, alu_data;
    logic        rf_write_enable;
    logic [2:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic        q1_hit, q2_hit;
    logic [15:0] q1_data, q2_data;
    logic [2:0]  count;
    logic        full, empty;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    bit  toggle_on;

    always #5 clk = ~clk;

    wb_write_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .drain_en(drain_en),
        .rf_write_enable(rf_write_enable),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .q1_addr(q1_addr), .q2_addr(q2_addr),
        .q1_hit(q1_hit), .q2_hit(q2_hit),
        .q1_data(q1_data), .q2_data(q2_data),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    // Monitor: every file write must match the oldest accepted result.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (count > 3'd4) begin
                failures++;
                $display("FAIL count_bound actual=%0d required<=4", count);
            end
            if (rf_write_enable) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=r%0d:%0h required=none",
                             rf_write_addr, rf_write_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (rf_write_addr !== e.a || rf_write_data !== e.d) begin
                        failures++;
                        $display("FAIL write_order actual=r%0d:%0h required=r%0d:%0h",
                                 rf_write_addr, rf_write_data, e.a, e.d);
                    end
                end
            end
        end
    end

    // Offer one or two results and hold each until it is accepted.
    task automatic drive(input logic mv, input logic [2:0] ma,
                         input logic [15:0] md, input logic av,
                         input logic [2:0] aa, input logic [15:0] ad);
        int  n;
        logic mr, ar;
        @(posedge clk);
        #1;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        n = 0;
        while ((mem_valid || alu_valid) && n < 40) begin
            @(negedge clk);
            mr = mem_ready;
            ar = alu_ready;
            @(posedge clk);
            if (mem_valid && mr) sb.push_back(mk(mem_addr, mem_data));
            if (alu_valid && ar) sb.push_back(mk(alu_addr, alu_data));
            #1;
            if (mr) mem_valid = 1'b0;
            if (ar) alu_valid = 1'b0;
            n++;
        end
        if (n >= 40) begin
            failures++;
            checks++;
            $display("FAIL drive_timeout actual=stuck required=accepted");
            mem_valid = 1'b0;
            alu_valid = 1'b0;
        end
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (!empty && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, empty, 1);
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 0; alu_valid = 0; drain_en = 0;
        mem_addr = 0; alu_addr = 0; mem_data = 0; alu_data = 0;
        q1_addr = 0; q2_addr = 0;
        toggle_on = 1'b0;

        // Reset state
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_wen", rf_write_enable, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_q1_hit", q1_hit, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single path with latency
        drain_en = 1'b1;
        drive(0, 0, 0, 1, 3'd3, 16'h1234);
        chk("single_wen", rf_write_enable, 1);
        chk("single_addr", rf_write_addr, 3);
        chk("single_data", rf_write_data, 16'h1234);
        @(posedge clk);
        #1;
        chk("single_empty", empty, 1);

        // Same-cycle ordering and forwarding of the youngest
        drain_en = 1'b0;
        drive(1, 3'd1, 16'h00AA, 1, 3'd1, 16'h00BB);
        q1_addr = 3'd1;
        #1;
        chk("order_count", count, 2);
        chk("order_q1_hit", q1_hit, 1);
        chk("order_q1_data", q1_data, 16'h00BB);
        drain_en = 1'b1;
        wait_empty("order_drain");

        // Forwarding hit/miss plus duplicate register
        drain_en = 1'b0;
        drive(0, 0, 0, 1, 3'd5, 16'h7777);
        q2_addr = 3'd5;
        #1;
        chk("fwd_hit", q2_hit, 1);
        chk("fwd_data", q2_data, 16'h7777);
        q2_addr = 3'd6;
        #1;
        chk("fwd_miss", q2_hit, 0);
        chk("fwd_miss_data", q2_data, 0);
        drive(1, 3'd5, 16'h8888, 0, 0, 0);
        q1_addr = 3'd5;
        q2_addr = 3'd5;
        #1;
        chk("fwd_dup_q1", q1_data, 16'h8888);
        chk("fwd_dup_q2", q2_data, 16'h8888);
        drain_en = 1'b1;
        wait_empty("fwd_drain");

        // Full and backpressure
        drain_en = 1'b0;
        drive(1, 3'd2, 16'h0011, 1, 3'd3, 16'h0022);
        drive(1, 3'd4, 16'h0033, 1, 3'd5, 16'h0044);
        chk("full_count", count, 4);
        chk("full_flag", full, 1);
        chk("full_mem_ready", mem_ready, 0);
        chk("full_alu_ready", alu_ready, 0);
        drain_en = 1'b1;
        @(posedge clk);
        #1 drain_en = 1'b0;
        chk("bp_count3", count, 3);
        mem_valid = 1; mem_addr = 3'd6; mem_data = 16'h0055;
        alu_valid = 1; alu_addr = 3'd7; alu_data = 16'h0066;
        #1;
        chk("bp_mem_ready", mem_ready, 1);
        chk("bp_alu_ready", alu_ready, 0);
        @(posedge clk);
        sb.push_back(mk(mem_addr, mem_data));
        #1 mem_valid = 1'b0;
        chk("bp_count4", count, 4);
        chk("bp_alu_held", alu_ready, 0);
        drain_en = 1'b1;
        begin
            int n;
            logic ar;
            n = 0;
            while (alu_valid && n < 20) begin
                @(negedge clk);
                ar = alu_ready;
                @(posedge clk);
                if (ar) sb.push_back(mk(alu_addr, alu_data));
                #1;
                if (ar) alu_valid = 1'b0;
                n++;
            end
            chk("bp_alu_accepted", alu_valid, 0);
            alu_valid = 1'b0;
        end
        wait_empty("bp_drain");

        // Wrap with alternating drain stalls
        drain_en = 1'b0;
        toggle_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    drive(1, 3'(2 * k), 16'(16'h5000 + 2 * k),
                          1, 3'(2 * k + 1), 16'(16'h5001 + 2 * k));
                toggle_on = 1'b0;
            end
            begin
                while (toggle_on) begin
                    @(posedge clk);
                    #1 drain_en = ~drain_en;
                end
            end
        join
        drain_en = 1'b1;
        wait_empty("wrap_drain");
        chk("wrap_all_written", sb.size(), 0);

        // Reset mid-stream discards pending entries
        drain_en = 1'b0;
        drive(1, 3'd1, 16'hC001, 1, 3'd2, 16'hC002);
        drive(1, 3'd3, 16'hC003, 0, 0, 0);
        chk("mid_count3", count, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_wen", rf_write_enable, 0);
        chk("mid_rst_alu_ready", alu_ready, 1);
        chk("mid_rst_q1_hit", q1_hit, 0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        drain_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
